// File: rtl/accelbrot_pkg.sv
// Shared types and helpers for the accelbrot task dispatcher.
package accelbrot_pkg;

    typedef enum logic {
        SEEK  = 1'b0,
        BURST = 1'b1
    } disp_state_t;

    // Widest request vector rr_pick accepts.
    localparam int unsigned RR_MAX = 32;

    // First set bit of req[n-1:0] scanning upward from last+1 (mod n).
    // Returns last when req is empty.
    function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] req,
                                            input int unsigned      last,
                                            input int unsigned      n);
        int unsigned idx;
        logic        found;
        rr_pick = last;
        found   = 1'b0;
        for (int unsigned i = 1; i <= n; i++) begin
            idx = (last + i) % n;
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/accelbrot_rr_arb.sv
// Round-robin arbiter with a registered last-grant pointer.
module accelbrot_rr_arb
    import accelbrot_pkg::*;
#(
    parameter int unsigned  N  = 3,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [N-1:0]  req,
    input  logic          adv,
    output logic [IW-1:0] gnt_idx,
    output logic [N-1:0]  gnt,
    output logic          any
);

    logic [IW-1:0] last;

    // Winner is the first requester after the last granted index.
    always_comb begin
        logic [RR_MAX-1:0] req_w;
        req_w          = '0;
        req_w[N-1:0]   = req;
        any            = |req;
        gnt_idx        = IW'(rr_pick(req_w, 32'(last), N));
        gnt            = any ? (N'(1) << gnt_idx) : '0;
    end

    // Pointer moves to the winner only when the grant is taken.
    always_ff @(posedge clk) begin
        if (!rstn)
            last <= IW'(N - 1);
        else if (adv && any)
            last <= gnt_idx;
    end

endmodule

// File: rtl/accelbrot_dispatch.sv
// Distributes whole word-serial tasks across iteration cores, merges
// core exits into one stream and tracks per-core in-flight credit.
module accelbrot_dispatch
    import accelbrot_pkg::*;
#(
    parameter int unsigned  NCORES     = 3,
    parameter int unsigned  NWORDS     = 8,
    parameter int unsigned  WWIDTH     = 34,
    parameter int unsigned  TWIDTH     = 24,
    parameter int unsigned  CWIDTH     = 20,
    parameter int unsigned  CORE_SLOTS = 16,
    localparam int unsigned CRWIDTH    = $clog2(CORE_SLOTS + 1)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [WWIDTH-1:0]        in_a,
    input  logic [WWIDTH-1:0]        in_b,
    input  logic [TWIDTH-1:0]        in_tag,
    input  logic                     in_start,
    input  logic                     in_valid,
    output logic                     in_bp,
    output logic [NCORES*WWIDTH-1:0] core_a,
    output logic [NCORES*WWIDTH-1:0] core_b,
    output logic [NCORES*TWIDTH-1:0] core_tag,
    output logic [NCORES-1:0]        core_start,
    output logic [NCORES-1:0]        core_valid,
    input  logic [NCORES-1:0]        core_bp,
    input  logic [NCORES*TWIDTH-1:0] cx_tag,
    input  logic [NCORES*CWIDTH-1:0] cx_count,
    input  logic [NCORES-1:0]        cx_valid,
    output logic [NCORES-1:0]        cx_ready,
    output logic [TWIDTH-1:0]        exit_tag,
    output logic [CWIDTH-1:0]        exit_count,
    output logic                     exit_valid,
    input  logic                     exit_ready,
    output logic [31:0]              sts_inflight,
    output logic                     sts_proto_err
);

    localparam int unsigned  IW      = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int unsigned  WCW     = $clog2(NWORDS + 1);
    localparam logic [CRWIDTH-1:0] SLOTS_C = CRWIDTH'(CORE_SLOTS);

    disp_state_t         state;
    logic [IW-1:0]       locked;
    logic [WCW-1:0]      wcnt;
    logic [CRWIDTH-1:0]  credit [NCORES];

    logic [WWIDTH-1:0]   fwd_a, fwd_b;
    logic [TWIDTH-1:0]   fwd_tag;
    logic                fwd_start;
    logic [NCORES-1:0]   fwd_valid;

    logic [NCORES-1:0]   cand, d_gnt, e_gnt, inc_vec;
    logic [IW-1:0]       d_idx, e_idx;
    logic                d_any, e_any;
    logic                xfer, start_take, e_take, err_set;
    logic [31:0]         credit_sum;

    accelbrot_rr_arb #(.N(NCORES)) u_disp_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (cand),
        .adv     (start_take),
        .gnt_idx (d_idx),
        .gnt     (d_gnt),
        .any     (d_any)
    );

    accelbrot_rr_arb #(.N(NCORES)) u_exit_arb (
        .clk     (clk),
        .rstn    (rstn),
        .req     (cx_valid),
        .adv     (e_take),
        .gnt_idx (e_idx),
        .gnt     (e_gnt),
        .any     (e_any)
    );

    // Candidate cores, input back-pressure, handshakes and error sources.
    always_comb begin
        logic underflow;
        underflow = 1'b0;
        for (int unsigned k = 0; k < NCORES; k++)
            cand[k] = (credit[k] < SLOTS_C) && !core_bp[k];

        if (!rstn)
            in_bp = 1'b1;
        else if (state == SEEK)
            in_bp = !d_any;
        else
            in_bp = core_bp[locked];

        xfer       = in_valid && !in_bp;
        start_take = xfer && in_start && d_any;
        e_take     = rstn && (!exit_valid || exit_ready) && e_any;
        cx_ready   = e_take ? e_gnt : '0;

        for (int unsigned k = 0; k < NCORES; k++) begin
            inc_vec[k] = start_take && (d_idx == IW'(k));
            if (cx_ready[k] && !inc_vec[k] && (credit[k] == '0))
                underflow = 1'b1;
        end

        err_set = (xfer && (state == SEEK) && !in_start)
               || (xfer && (state == BURST) && in_start)
               || underflow;

        credit_sum = '0;
        for (int unsigned k = 0; k < NCORES; k++)
            credit_sum = credit_sum + 32'(credit[k]);
    end

    // Dispatch FSM: a start beat always reselects a core, so a start seen
    // mid-burst abandons the old task and begins a fresh one.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= SEEK;
            locked    <= '0;
            wcnt      <= '0;
            fwd_valid <= '0;
        end else begin
            fwd_valid <= '0;
            if (xfer) begin
                if (in_start) begin
                    if (d_any) begin
                        fwd_valid <= d_gnt;
                        locked    <= d_idx;
                        if (NWORDS == 1) begin
                            state <= SEEK;
                            wcnt  <= '0;
                        end else begin
                            state <= BURST;
                            wcnt  <= WCW'(1);
                        end
                    end else begin
                        state <= SEEK;
                    end
                end else if (state == BURST) begin
                    fwd_valid <= NCORES'(1) << locked;
                    wcnt      <= wcnt + 1'b1;
                    if (wcnt == WCW'(NWORDS - 1))
                        state <= SEEK;
                end
            end
        end
    end

    // Beat payload register shared by all lanes.
    always_ff @(posedge clk) begin
        if (xfer) begin
            fwd_a     <= in_a;
            fwd_b     <= in_b;
            fwd_tag   <= in_tag;
            fwd_start <= in_start;
        end
    end

    assign core_a     = {NCORES{fwd_a}};
    assign core_b     = {NCORES{fwd_b}};
    assign core_tag   = {NCORES{fwd_tag}};
    assign core_start = {NCORES{fwd_start}};
    assign core_valid = fwd_valid;

    // One-entry exit register, reloaded on the same cycle it drains.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            exit_valid <= 1'b0;
            exit_tag   <= '0;
            exit_count <= '0;
        end else if (e_take) begin
            exit_valid <= 1'b1;
            exit_tag   <= cx_tag[e_idx*TWIDTH +: TWIDTH];
            exit_count <= cx_count[e_idx*CWIDTH +: CWIDTH];
        end else if (exit_ready) begin
            exit_valid <= 1'b0;
        end
    end

    // Per-core credit, in-flight total and sticky protocol error.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned k = 0; k < NCORES; k++)
                credit[k] <= '0;
            sts_inflight  <= '0;
            sts_proto_err <= 1'b0;
        end else begin
            for (int unsigned k = 0; k < NCORES; k++) begin
                if (inc_vec[k] && !cx_ready[k])
                    credit[k] <= credit[k] + 1'b1;
                else if (cx_ready[k] && !inc_vec[k] && (credit[k] != '0))
                    credit[k] <= credit[k] - 1'b1;
            end
            sts_inflight <= credit_sum;
            if (err_set)
                sts_proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_accelbrot_dispatch.sv
// Directed bench for accelbrot_dispatch (CORE_SLOTS reduced to 2).
module tb_accelbrot_dispatch;

    localparam int NC = 3;
    localparam int NW = 8;

    logic           clk = 1'b0;
    logic           rstn;
    logic [33:0]    in_a, in_b;
    logic [23:0]    in_tag;
    logic           in_start, in_valid, in_bp;
    logic [NC*34-1:0] core_a, core_b;
    logic [NC*24-1:0] core_tag;
    logic [NC-1:0]  core_start, core_valid, core_bp;
    logic [NC*24-1:0] cx_tag;
    logic [NC*20-1:0] cx_count;
    logic [NC-1:0]  cx_valid, cx_ready;
    logic [23:0]    exit_tag;
    logic [19:0]    exit_count;
    logic           exit_valid, exit_ready;
    logic [31:0]    sts_inflight;
    logic           sts_proto_err;

    accelbrot_dispatch #(.NCORES(NC), .NWORDS(NW), .CORE_SLOTS(2)) dut (
        .clk(clk), .rstn(rstn),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .in_start(in_start),
        .in_valid(in_valid), .in_bp(in_bp),
        .core_a(core_a), .core_b(core_b), .core_tag(core_tag),
        .core_start(core_start), .core_valid(core_valid), .core_bp(core_bp),
        .cx_tag(cx_tag), .cx_count(cx_count), .cx_valid(cx_valid), .cx_ready(cx_ready),
        .exit_tag(exit_tag), .exit_count(exit_count), .exit_valid(exit_valid),
        .exit_ready(exit_ready), .sts_inflight(sts_inflight), .sts_proto_err(sts_proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          core;
        logic [33:0] a;
        logic [23:0] tag;
        logic        start;
    } beat_t;

    typedef struct {
        bit       rst_before;
        logic [2:0] bp;
        int       exp_core;
        int       exp_inflight;
    } vec_t;

    beat_t rxq[$];
    int checks = 0, passed = 0, onehot_viol = 0, last_waits = 0;
    logic [2:0] bp_drive = '0;

    task automatic chk(input string name, input bit ok, input longint act, input longint exp);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Capture every forwarded beat in arrival order.
    always @(negedge clk) begin
        if (rstn === 1'b1) begin
            if ($countones(core_valid) > 1) onehot_viol++;
            for (int k = 0; k < NC; k++) begin
                if (core_valid[k]) begin
                    beat_t b;
                    b.core = k; b.a = core_a[k*34 +: 34];
                    b.tag = core_tag[k*24 +: 24]; b.start = core_start[k];
                    rxq.push_back(b);
                end
            end
        end
    end

    task automatic send_beat(input logic [33:0] a, input logic [23:0] tag, input logic st);
        int w;
        w = 0;
        @(negedge clk);
        core_bp = bp_drive; in_valid = 1'b1; in_a = a; in_b = a + 34'd1000;
        in_tag = tag; in_start = st;
        #1;
        while (in_bp && w < 200) begin @(negedge clk); #1; w++; end
        last_waits = w;
        if (w >= 200) begin
            checks++;
            $display("FAIL send_timeout: got %0d waits expected <200", w);
        end
    endtask

    task automatic send_task(input int idx);
        for (int i = 0; i < NW; i++)
            send_beat(34'(idx*16 + i), 24'(256 + idx), i == 0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); in_valid = 1'b0; in_start = 1'b0; end
    endtask

    task automatic check_task(input int exp_core, input int idx, input int n);
        int core0; bit ok; beat_t b;
        ok = (rxq.size() >= n);
        core0 = -1;
        for (int i = 0; i < n && rxq.size() > 0; i++) begin
            b = rxq.pop_front();
            if (i == 0) core0 = b.core;
            if (b.core != exp_core || b.a != 34'(idx*16 + i) || b.tag != 24'(256 + idx)
                || b.start != (i == 0)) ok = 1'b0;
        end
        chk($sformatf("route_t%0d", idx), core0 == exp_core, core0, exp_core);
        chk($sformatf("beats_t%0d", idx), ok, ok, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; in_valid = 1'b0; in_start = 1'b0; cx_valid = '0;
        core_bp = '0; bp_drive = '0; exit_ready = 1'b1;
        #1;
        chk("bp_in_reset", in_bp == 1'b1, in_bp, 1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        rxq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[10];
        int hold, hold_bad, hold_seen;
        bit prev_hold;
        logic [23:0] held_tag;
        logic [19:0] held_cnt;
        logic [2:0] clr;
        logic [23:0] got_tag[$];
        logic [19:0] got_cnt[$];

        vt[0] = '{1, 3'b000, 0, 1}; vt[1] = '{0, 3'b000, 1, 2};
        vt[2] = '{0, 3'b000, 2, 3}; vt[3] = '{0, 3'b000, 0, 4};
        vt[4] = '{0, 3'b000, 1, 5}; vt[5] = '{0, 3'b000, 2, 6};
        vt[6] = '{1, 3'b010, 0, 1}; vt[7] = '{0, 3'b010, 2, 2};
        vt[8] = '{0, 3'b010, 0, 3}; vt[9] = '{0, 3'b010, 2, 4};

        rstn = 1'b0; in_a = '0; in_b = '0; in_tag = '0; in_start = 1'b0;
        in_valid = 1'b0; core_bp = '0; cx_tag = '0; cx_count = '0;
        cx_valid = '0; exit_ready = 1'b1;

        // Reset state
        do_reset();
        @(negedge clk); #1;
        chk("rst_core_valid", core_valid == '0, core_valid, 0);
        chk("rst_cx_ready", cx_ready == '0, cx_ready, 0);
        chk("rst_exit_valid", exit_valid == 1'b0, exit_valid, 0);
        chk("rst_inflight", sts_inflight == 0, sts_inflight, 0);
        chk("rst_err", sts_proto_err == 1'b0, sts_proto_err, 0);

        // Round-robin routing, with and without a back-pressured core
        for (int i = 0; i < 10; i++) begin
            if (vt[i].rst_before) do_reset();
            bp_drive = vt[i].bp;
            send_task(i);
            idle(2);
            check_task(vt[i].exp_core, i, NW);
            chk($sformatf("inflight_v%0d", i), sts_inflight == 32'(vt[i].exp_inflight),
                sts_inflight, vt[i].exp_inflight);
        end
        chk("no_err_routing", sts_proto_err == 1'b0, sts_proto_err, 0);

        // Core back-pressure mid-burst
        do_reset();
        for (int i = 0; i < 3; i++) send_beat(34'(20*16 + i), 24'(256 + 20), i == 0);
        hold = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            core_bp = 3'b001; in_valid = 1'b1; in_start = 1'b0;
            in_a = 34'(20*16 + 3); in_tag = 24'(256 + 20);
            #1;
            if (in_bp) hold++;
        end
        chk("bp_hold_cycles", hold == 5, hold, 5);
        bp_drive = '0;
        for (int i = 3; i < NW; i++) begin
            send_beat(34'(20*16 + i), 24'(256 + 20), 1'b0);
            if (i == 3) chk("bp_release", last_waits == 0, last_waits, 0);
        end
        idle(2);
        check_task(0, 20, NW);
        chk("bp_no_dup", rxq.size() == 0, rxq.size(), 0);

        // Credit exhaustion and release by one exit
        do_reset();
        for (int i = 0; i < 6; i++) send_task(30 + i);
        idle(2);
        for (int i = 0; i < 6; i++) check_task(i % 3, 30 + i, NW);
        @(negedge clk);
        in_valid = 1'b1; in_start = 1'b1; in_a = 34'(36*16); in_tag = 24'(256 + 36);
        hold = 0;
        repeat (4) begin #1; if (in_bp) hold++; @(negedge clk); end
        chk("full_bp", hold == 4, hold, 4);
        cx_valid = 3'b010; cx_tag[24 +: 24] = 24'h0E1; cx_count[20 +: 20] = 20'd77;
        #1;
        chk("full_cx_ready", cx_ready == 3'b010, cx_ready, 3'b010);
        chk("full_bp_pre", in_bp == 1'b1, in_bp, 1);
        @(negedge clk);
        cx_valid = '0;
        #1;
        chk("full_bp_free", in_bp == 1'b0, in_bp, 0);
        chk("full_exit_valid", exit_valid == 1'b1, exit_valid, 1);
        chk("full_exit_tag", exit_tag == 24'h0E1, exit_tag, 24'h0E1);
        for (int i = 1; i < NW; i++) send_beat(34'(36*16 + i), 24'(256 + 36), 1'b0);
        idle(2);
        check_task(1, 36, NW);
        chk("full_inflight", sts_inflight == 6, sts_inflight, 6);

        // Exit merge ordering under toggling exit_ready
        do_reset();
        for (int i = 0; i < 3; i++) send_task(40 + i);
        idle(2);
        for (int i = 0; i < 3; i++) check_task(i, 40 + i, NW);
        chk("exit_pre_inflight", sts_inflight == 3, sts_inflight, 3);
        cx_tag = {24'hC, 24'hB, 24'hA};
        cx_count = {20'd300, 20'd200, 20'd100};
        clr = '0; prev_hold = 1'b0; hold_bad = 0; hold_seen = 0;
        held_tag = '0; held_cnt = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            exit_ready = (c % 2 == 0);
            if (c == 0) cx_valid = 3'b111; else cx_valid = cx_valid & ~clr;
            #1;
            if (prev_hold) begin
                hold_seen++;
                if (!exit_valid || exit_tag != held_tag || exit_count != held_cnt) hold_bad++;
            end
            prev_hold = exit_valid && !exit_ready;
            held_tag = exit_tag; held_cnt = exit_count;
            if (exit_valid && exit_ready) begin
                got_tag.push_back(exit_tag); got_cnt.push_back(exit_count);
            end
            clr = cx_ready;
        end
        exit_ready = 1'b1;
        idle(2);
        chk("exit_num", got_tag.size() == 3, got_tag.size(), 3);
        if (got_tag.size() == 3) begin
            chk("exit_0", got_tag[0] == 24'hA && got_cnt[0] == 20'd100, got_tag[0], 24'hA);
            chk("exit_1", got_tag[1] == 24'hB && got_cnt[1] == 20'd200, got_tag[1], 24'hB);
            chk("exit_2", got_tag[2] == 24'hC && got_cnt[2] == 20'd300, got_tag[2], 24'hC);
        end
        chk("exit_hold", hold_bad == 0 && hold_seen == 3, hold_bad, 0);
        chk("exit_inflight", sts_inflight == 0, sts_inflight, 0);
        chk("exit_no_err", sts_proto_err == 1'b0, sts_proto_err, 0);

        // Stray non-start beat in SEEK is dropped and flagged
        do_reset();
        send_beat(34'h5, 24'h5, 1'b0);
        idle(2);
        chk("stray_dropped", rxq.size() == 0, rxq.size(), 0);
        chk("stray_err", sts_proto_err == 1'b1, sts_proto_err, 1);

        // Start beat mid-burst
        do_reset();
        send_task(50);
        for (int i = 0; i < 4; i++) send_beat(34'(51*16 + i), 24'(256 + 51), i == 0);
        send_task(52);
        idle(2);
        chk("midstart_err", sts_proto_err == 1'b1, sts_proto_err, 1);
        send_task(53);
        idle(2);
        check_task(0, 50, NW);
        check_task(1, 51, 4);
        check_task(2, 52, NW);
        check_task(0, 53, NW);
        chk("midstart_err_sticky", sts_proto_err == 1'b1, sts_proto_err, 1);
        chk("midstart_inflight", sts_inflight == 4, sts_inflight, 4);
        do_reset();
        idle(1);
        #1;
        chk("err_cleared", sts_proto_err == 1'b0, sts_proto_err, 0);

        chk("lane_onehot", onehot_viol == 0, onehot_viol, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
